// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor that steps one full_subtractor cell over the operands, LSB first.
// Latency: WIDTH cycles from the accepting edge to done; one operation per WIDTH+2 cycles.
// Backpressure: none. start is sampled only in IDLE and ignored while busy or done.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start                request; accepted only when idle
//   a_in, b_in           minuend / subtrahend, captured on the accepting edge
//   borrow_in            initial borrow, captured on the accepting edge
//   busy                 high while bits are being processed
//   done                 one-cycle pulse, diff/borrow_out/zero valid
//   diff                 difference (result shift register)
//   borrow_out, zero     final borrow and all-zero flag, held until the next result

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic B_in,
   output logic D,
   output logic B_out
);
   assign D     = a ^ b ^ B_in;
   assign B_out = (~a & b) | (~(a ^ b) & B_in);
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_sh;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             b_bit;
   logic [WIDTH-1:0] diff_nxt;

   full_subtractor u_fs (
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .B_in  (brw),
      .D     (d_bit),
      .B_out (b_bit)
   );

   // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   assign diff_nxt = {d_bit, diff_sh[WIDTH-1:1]};
   assign diff     = diff_sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         diff_sh    <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh    <= a_in;
                  b_sh    <= b_in;
                  brw     <= borrow_in;
                  cnt     <= '0;
                  diff_sh <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               diff_sh <= diff_nxt;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               brw     <= b_bit;
               cnt     <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  // Flags are taken from the values being written on this last
                  // edge, so they describe the completed result.
                  state      <= S_DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  borrow_out <= b_bit;
                  zero       <= (diff_nxt == '0);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       borrow_in;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow_out;
   logic       zero;

   int n_checks = 0;
   int n_errors = 0;

   serial_subtractor_ctrl #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a_in       (a_in),
      .b_in       (b_in),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain 9-bit arithmetic on the operands.
   function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
      return {1'b0, a} - {1'b0, b} - {8'b0, bi};
   endfunction

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit scramble);
      logic [8:0] r;
      int k;
      int busy_cnt;
      bit seen;
      r = ref_sub(a, b, bi);
      @(negedge clk);
      start = 1'b1; a_in = a; b_in = b; borrow_in = bi;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cnt = 0;
      seen = 0;
      for (k = 1; k <= 20; k++) begin
         if (busy) busy_cnt++;
         if (scramble) begin
            a_in = 8'($urandom); b_in = 8'($urandom); borrow_in = 1'($urandom);
         end
         @(posedge clk); #1;
         if (done) begin
            seen = 1;
            break;
         end
      end
      check("done_seen", 32'(seen), 1);
      check("latency", k, 8);
      check("busy_cycles", busy_cnt, 8);
      check("busy_at_done", 32'(busy), 0);
      check("diff", 32'(diff), 32'(r[7:0]));
      check("borrow_out", 32'(borrow_out), 32'(r[8]));
      check("zero", 32'(zero), 32'(r[7:0] == 8'h00));
      @(posedge clk); #1;
      check("done_fall", 32'(done), 0);
   endtask

   initial begin
      logic [8:0] r;
      int dones;
      int last_done;
      logic [7:0] cap_diff;
      logic cap_brw;

      rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; borrow_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_diff", 32'(diff), 0);
      check("rst_borrow", 32'(borrow_out), 0);
      check("rst_zero", 32'(zero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      do_op(8'h05, 8'h03, 1'b0, 0);
      do_op(8'h03, 8'h05, 1'b0, 0);
      do_op(8'h80, 8'h7F, 1'b1, 0);
      do_op(8'hFF, 8'hFF, 1'b0, 0);
      do_op(8'h00, 8'h00, 1'b1, 0);

      // Start pulse with new operands during RUN must be ignored.
      @(negedge clk);
      start = 1'b1; a_in = 8'h10; b_in = 8'h01; borrow_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0; cap_diff = '0; cap_brw = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 3) begin start = 1'b1; a_in = 8'h00; b_in = 8'hFF; end
         if (c == 4) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            dones++;
            cap_diff = diff;
            cap_brw = borrow_out;
         end
      end
      check("ign_dones", dones, 1);
      check("ign_diff", 32'(cap_diff), 32'h0F);
      check("ign_borrow", 32'(cap_brw), 0);

      // Mid-RUN reset; previous result left borrow_out=1 so the clear is visible.
      do_op(8'h00, 8'h01, 1'b0, 0);
      @(negedge clk);
      start = 1'b1; a_in = 8'h55; b_in = 8'h11; borrow_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_diff", 32'(diff), 0);
      check("mid_rst_borrow", 32'(borrow_out), 0);
      check("mid_rst_zero", 32'(zero), 0);
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (c == 3) begin @(negedge clk); rst_n = 1'b1; end
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("mid_rst_no_done", dones, 0);
      do_op(8'h20, 8'h21, 1'b0, 0);

      // Randomised operations, operands scrambled while running.
      for (int i = 0; i < 40; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom), 1);
      end

      // start held high: back-to-back operations every WIDTH+2 cycles.
      r = ref_sub(8'hA7, 8'h3C, 1'b1);
      @(negedge clk);
      start = 1'b1; a_in = 8'hA7; b_in = 8'h3C; borrow_in = 1'b1;
      dones = 0; last_done = -1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (done) begin
            if (last_done < 0) check("tp_first", c, 8);
            else check("tp_interval", c - last_done, 10);
            check("tp_diff", 32'(diff), 32'(r[7:0]));
            check("tp_borrow", 32'(borrow_out), 32'(r[8]));
            last_done = c;
            dones++;
         end
      end
      start = 1'b0;
      check("tp_count", dones, 5);
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
